// File: rtl/icache_ctrl_nway.sv
// N-way set-associative instruction cache controller with round-robin replacement,
// sequential flush, registered CPU/L2 handshake and saturating hit/miss counters.
module icache_ctrl_nway #(
    parameter int ADDR_W   = 30,
    parameter int WAYS     = 2,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 2,
    parameter int CNT_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic                         flush,
    output logic                         cpu_rdy,
    output logic [31:0]                  cpu_data,
    output logic                         miss_stall,
    output logic                         l2_req,
    output logic [ADDR_W-OFFSET_W-1:0]   l2_addr,
    input  logic                         l2_rdy,
    input  logic [(32<<OFFSET_W)-1:0]    l2_data,
    output logic [CNT_W-1:0]             hit_cnt,
    output logic [CNT_W-1:0]             miss_cnt
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS  = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int WAY_W = $clog2(WAYS);

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {S_FLUSH, S_READY, S_MISS} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0]               tag_mem  [WAYS][SETS];
    line_t                          data_mem [WAYS][SETS];
    logic [SETS-1:0][WAYS-1:0]      valid;
    logic [SETS-1:0][WAY_W-1:0]     rr_ptr;

    logic [INDEX_W-1:0]  flush_idx;
    logic                flush_pend;
    logic [OFFSET_W-1:0] lat_word;

    logic [TAG_W-1:0]    req_tag;
    logic [INDEX_W-1:0]  req_idx;
    logic [OFFSET_W-1:0] req_word;
    logic [TAG_W-1:0]    lat_tag;
    logic [INDEX_W-1:0]  lat_idx;
    line_t               fill_line;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             free_found;
    logic [WAY_W-1:0] victim;
    logic             do_hit, do_miss, do_fill;

    assign req_tag   = cpu_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign req_idx   = cpu_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign req_word  = cpu_addr[OFFSET_W-1:0];
    // l2_addr doubles as the latched {tag,index} of the outstanding miss
    assign lat_tag   = l2_addr[ADDR_W-OFFSET_W-1:INDEX_W];
    assign lat_idx   = l2_addr[INDEX_W-1:0];
    assign fill_line = l2_data;
    assign miss_stall = (state_q != S_READY);

    // Lowest matching way wins should more than one way ever hit
    always_comb begin
        logic [WAY_W-1:0] w_i;
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_i = WAY_W'(w);
            if (!hit && valid[req_idx][w_i] && tag_mem[w_i][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = w_i;
            end
        end
    end

    always_comb begin
        logic [WAY_W-1:0] w_i;
        free_found = 1'b0;
        victim     = rr_ptr[lat_idx];
        for (int unsigned w = 0; w < WAYS; w++) begin
            w_i = WAY_W'(w);
            if (!free_found && !valid[lat_idx][w_i]) begin
                free_found = 1'b1;
                victim     = w_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FLUSH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        do_hit  = 1'b0;
        do_miss = 1'b0;
        do_fill = 1'b0;
        case (state_q)
            S_FLUSH: if (flush_idx == '1) state_d = S_READY;
            S_READY: begin
                if (flush) begin
                    state_d = S_FLUSH;
                end else if (cpu_req) begin
                    if (hit) begin
                        do_hit = 1'b1;
                    end else begin
                        do_miss = 1'b1;
                        state_d = S_MISS;
                    end
                end
            end
            S_MISS: begin
                if (l2_rdy) begin
                    do_fill = 1'b1;
                    state_d = (flush_pend || flush) ? S_FLUSH : S_READY;
                end
            end
            default: state_d = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            rr_ptr     <= '0;
            flush_idx  <= '0;
            flush_pend <= 1'b0;
            lat_word   <= '0;
            cpu_rdy    <= 1'b0;
            cpu_data   <= '0;
            l2_req     <= 1'b0;
            l2_addr    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            cpu_rdy <= 1'b0;
            if (state_q == S_FLUSH) begin
                valid[flush_idx] <= '0;
                flush_idx        <= flush_idx + 1'b1;
            end
            if (do_hit) begin
                cpu_rdy  <= 1'b1;
                cpu_data <= data_mem[hit_way][req_idx][req_word];
                if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
            end
            if (do_miss) begin
                l2_req   <= 1'b1;
                l2_addr  <= cpu_addr[ADDR_W-1:OFFSET_W];
                lat_word <= req_word;
                if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
            if (do_fill) begin
                valid[lat_idx][victim] <= 1'b1;
                if (!free_found) rr_ptr[lat_idx] <= rr_ptr[lat_idx] + 1'b1;
                l2_req     <= 1'b0;
                cpu_rdy    <= 1'b1;
                cpu_data   <= fill_line[lat_word];
                flush_pend <= 1'b0;
            end else if (state_q == S_MISS && flush) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_fill) begin
            tag_mem[victim][lat_idx]  <= lat_tag;
            data_mem[victim][lat_idx] <= fill_line;
        end
    end

endmodule

// File: tb/tb_icache_ctrl_nway.sv
// Randomised self-checking bench for icache_ctrl_nway against an array-based
// reference cache (lowest-free-way / round-robin replacement, saturating counters).
module tb_icache_ctrl_nway;
    localparam int ADDR_W   = 30;
    localparam int WAYS     = 2;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 2;
    localparam int CNT_W    = 4;
    localparam int LINE_W   = 32 << OFFSET_W;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 1 << INDEX_W;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic                       cpu_req = 1'b0;
    logic [ADDR_W-1:0]          cpu_addr = '0;
    logic                       flush = 1'b0;
    logic                       cpu_rdy;
    logic [31:0]                cpu_data;
    logic                       miss_stall;
    logic                       l2_req;
    logic [ADDR_W-OFFSET_W-1:0] l2_addr;
    logic                       l2_rdy = 1'b0;
    logic [LINE_W-1:0]          l2_data = '0;
    logic [CNT_W-1:0]           hit_cnt;
    logic [CNT_W-1:0]           miss_cnt;

    icache_ctrl_nway #(
        .ADDR_W(ADDR_W), .WAYS(WAYS), .INDEX_W(INDEX_W),
        .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
        .cpu_rdy(cpu_rdy), .cpu_data(cpu_data), .miss_stall(miss_stall),
        .l2_req(l2_req), .l2_addr(l2_addr), .l2_rdy(l2_rdy), .l2_data(l2_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit                mvalid [WAYS][SETS];
    logic [TAG_W-1:0]  mtag   [WAYS][SETS];
    logic [LINE_W-1:0] mdata  [WAYS][SETS];
    int                mrr    [SETS];
    int                exp_hits;
    int                exp_miss;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [LINE_W-1:0] line, input int w);
        return line[w*32 +: 32];
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    function automatic logic [ADDR_W-1:0] mk_addr(input int tag, input int idx, input int w);
        return ADDR_W'((tag << (INDEX_W + OFFSET_W)) | (idx << OFFSET_W) | w);
    endfunction

    task automatic model_invalidate();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) mvalid[w][s] = 1'b0;
    endtask

    task automatic model_reset();
        model_invalidate();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    // Counts stall cycles while hammering cpu_req; a flush must last exactly SETS cycles
    task automatic wait_flush(input string tag);
        int n;
        bit rdy_seen;
        n = 0;
        rdy_seen = 1'b0;
        while (miss_stall === 1'b1 && n < 1000) begin
            n++;
            cpu_req  = 1'b1;
            cpu_addr = ADDR_W'($urandom);
            @(posedge clk); #1;
            if (cpu_rdy !== 1'b0) rdy_seen = 1'b1;
        end
        cpu_req = 1'b0;
        check({tag, "_len"}, n, SETS);
        check({tag, "_no_rdy"}, 32'(rdy_seen), 0);
        check({tag, "_hit_cnt"}, 32'(hit_cnt), exp_hits);
        check({tag, "_miss_cnt"}, 32'(miss_cnt), exp_miss);
        model_invalidate();
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] addr, input int dly,
                         input logic [LINE_W-1:0] line, input int flush_at,
                         output bit saw_miss);
        logic [TAG_W-1:0] t;
        int idx, wd, way, v;
        bit m_hit, pend;
        t   = addr[ADDR_W-1:INDEX_W+OFFSET_W];
        idx = int'(addr[INDEX_W+OFFSET_W-1:OFFSET_W]);
        wd  = int'(addr[OFFSET_W-1:0]);
        m_hit = 1'b0;
        way = 0;
        for (int w = 0; w < WAYS; w++)
            if (!m_hit && mvalid[w][idx] && mtag[w][idx] == t) begin
                m_hit = 1'b1;
                way = w;
            end
        cpu_req  = 1'b1;
        cpu_addr = addr;
        @(posedge clk); #1;
        cpu_req  = 1'b0;
        saw_miss = l2_req;
        if (m_hit) begin
            exp_hits = sat_inc(exp_hits);
            check("hit_rdy", 32'(cpu_rdy), 1);
            check("hit_data", cpu_data, word_of(mdata[way][idx], wd));
            check("hit_no_l2", 32'(l2_req), 0);
            check("hit_cnt", 32'(hit_cnt), exp_hits);
        end else begin
            exp_miss = sat_inc(exp_miss);
            check("miss_no_rdy", 32'(cpu_rdy), 0);
            check("miss_l2_req", 32'(l2_req), 1);
            check("miss_l2_addr", 32'(l2_addr), 32'(addr[ADDR_W-1:OFFSET_W]));
            check("miss_cnt", 32'(miss_cnt), exp_miss);
            check("miss_stall", 32'(miss_stall), 1);
            pend = (flush_at >= 0 && flush_at < dly);
            for (int c = 0; c < dly; c++) begin
                if (c == flush_at) flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                check("wait_l2_req", 32'(l2_req), 1);
                check("wait_l2_addr", 32'(l2_addr), 32'(addr[ADDR_W-1:OFFSET_W]));
                check("wait_no_rdy", 32'(cpu_rdy), 0);
            end
            l2_rdy  = 1'b1;
            l2_data = line;
            @(posedge clk); #1;
            l2_rdy  = 1'b0;
            check("fill_rdy", 32'(cpu_rdy), 1);
            check("fill_data", cpu_data, word_of(line, wd));
            check("fill_l2_drop", 32'(l2_req), 0);
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !mvalid[w][idx]) v = w;
            if (v < 0) begin
                v = mrr[idx];
                mrr[idx] = (mrr[idx] + 1) % WAYS;
            end
            mvalid[v][idx] = 1'b1;
            mtag[v][idx]   = t;
            mdata[v][idx]  = line;
            if (pend) wait_flush("pend_flush");
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        bit m;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] line0;
        int fa, dly;

        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cpu_rdy", 32'(cpu_rdy), 0);
        check("rst_cpu_data", cpu_data, 0);
        check("rst_l2_req", 32'(l2_req), 0);
        check("rst_l2_addr", 32'(l2_addr), 0);
        check("rst_hit_cnt", 32'(hit_cnt), 0);
        check("rst_miss_cnt", 32'(miss_cnt), 0);
        check("rst_stall", 32'(miss_stall), 1);
        rst = 1'b0;
        wait_flush("boot_flush");

        // Cold fetch, critical word, then hits from the same line
        line0 = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
        fetch(30'h41, 5, line0, -1, m);
        check("cold_miss", 32'(m), 1);
        check("cold_data", cpu_data, 32'hDEADBEEF);
        fetch(30'h43, 0, '0, -1, m);
        check("warm_hit", 32'(m), 0);
        check("warm_data", cpu_data, 32'h33333333);
        for (int i = 0; i < 4; i++) fetch(ADDR_W'(32'h40 + i), 0, '0, -1, m);
        for (int i = 0; i < 20; i++) fetch(ADDR_W'(32'h40 + (i % 4)), 0, '0, -1, m);
        check("hit_sat", 32'(hit_cnt), CNT_MAX);

        // Three lines competing for one 2-way set
        fetch(mk_addr(1, 5, 0), 1, rand_line(), -1, m);
        fetch(mk_addr(2, 5, 1), 2, rand_line(), -1, m);
        fetch(mk_addr(3, 5, 2), 0, rand_line(), -1, m);
        check("C_miss", 32'(m), 1);
        fetch(mk_addr(1, 5, 3), 1, rand_line(), -1, m);
        check("A_refetch_miss", 32'(m), 1);
        fetch(mk_addr(3, 5, 0), 0, '0, -1, m);
        check("C_still_hit", 32'(m), 0);
        fetch(mk_addr(2, 5, 0), 0, rand_line(), -1, m);
        check("B_evicted", 32'(m), 1);

        // Flush arriving while a refill is outstanding
        fetch(30'h80, 4, rand_line(), 1, m);
        fetch(30'h81, 2, rand_line(), -1, m);
        check("post_flush_miss", 32'(m), 1);

        for (int i = 0; i < 150; i++) begin
            a   = mk_addr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            dly = $urandom_range(0, 4);
            fa  = ($urandom_range(0, 19) == 0 && dly > 0) ? $urandom_range(0, dly - 1) : -1;
            fetch(a, dly, rand_line(), fa, m);
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
                @(posedge clk); #1;
                flush = 1'b0;
                check("ready_flush_no_rdy", 32'(cpu_rdy), 0);
                wait_flush("ready_flush");
            end
        end

        // Reset in the middle of a refill
        a = mk_addr(85, 48, 1);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        check("rstmiss_l2_req", 32'(l2_req), 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmiss_l2_drop", 32'(l2_req), 0);
        check("rstmiss_no_rdy", 32'(cpu_rdy), 0);
        check("rstmiss_hit_cnt", 32'(hit_cnt), 0);
        check("rstmiss_miss_cnt", 32'(miss_cnt), 0);
        rst = 1'b0;
        model_reset();
        l2_rdy  = 1'b1;
        l2_data = rand_line();
        wait_flush("rstmiss_flush");
        l2_rdy = 1'b0;
        fetch(a, 1, rand_line(), -1, m);
        check("rstmiss_refetch_miss", 32'(m), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
